// File: rtl/spike_generator_bank.sv
// rtl/spike_generator_bank.sv - bank of programmable periodic spike generators emitting tag/count words
module spike_generator_bank #(
  parameter int Ngens   = 8,
  parameter int Nperiod = 16,
  parameter int Ntag    = 11,
  parameter int Nct     = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  unit_pulse,
  input  logic [Ngens-1:0]      gens_used,
  input  logic [2**Ngens-1:0]   gens_en,
  input  logic [Ngens-1:0]      prog_gen_idx,
  input  logic [Nperiod-1:0]    prog_period,
  input  logic [Nperiod-1:0]    prog_ticks,
  input  logic [Ntag-1:0]       prog_tag,
  input  logic                  prog_v,
  output logic                  prog_a,
  output logic [Ntag-1:0]       out_tag,
  output logic [Nct-1:0]        out_ct,
  output logic                  out_v,
  input  logic                  out_a,
  output logic                  overrun
);

  localparam int Depth = 2**Ngens;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  logic [Nperiod-1:0] period_mem [Depth];
  logic [Nperiod-1:0] ticks_mem  [Depth];
  logic [Ntag-1:0]    tag_mem    [Depth];

  logic [1:0]         state;
  logic [Ngens-1:0]   idx;
  logic               pending;

  logic [Nperiod-1:0] cur_period;
  logic [Nperiod-1:0] cur_ticks;
  logic               cur_live;
  logic               cur_fire;
  logic               last_idx;

  assign cur_period = period_mem[idx];
  assign cur_ticks  = ticks_mem[idx];
  assign cur_live   = gens_en[idx] && (cur_period != '0);
  assign cur_fire   = cur_live && (cur_ticks <= Nperiod'(1));
  assign last_idx   = (idx == gens_used);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        period_mem[i] <= '0;
        ticks_mem[i]  <= '0;
        tag_mem[i]    <= '0;
      end
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      prog_a  <= 1'b0;
      out_v   <= 1'b0;
      out_tag <= '0;
      out_ct  <= '0;
    end else begin
      prog_a <= 1'b0;
      // Only one time unit can be queued behind an active scan; a second is lost.
      if (unit_pulse && (state != IDLE)) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (unit_pulse || pending) begin
            pending <= 1'b0;
            idx     <= '0;
            state   <= SCAN;
          end else if (prog_v && !prog_a) begin
            // prog_a high doubles as the one-cycle hold-off for a still-held prog_v.
            period_mem[prog_gen_idx] <= prog_period;
            ticks_mem[prog_gen_idx]  <= prog_ticks;
            tag_mem[prog_gen_idx]    <= prog_tag;
            prog_a                   <= 1'b1;
          end
        end
        SCAN: begin
          if (cur_fire) begin
            ticks_mem[idx] <= cur_period;
            out_tag        <= tag_mem[idx];
            out_ct         <= Nct'(1);
            out_v          <= 1'b1;
            state          <= EMIT;
          end else begin
            if (cur_live) ticks_mem[idx] <= cur_ticks - Nperiod'(1);
            if (last_idx) state <= IDLE;
            else          idx   <= idx + Ngens'(1);
          end
        end
        EMIT: begin
          if (out_a) begin
            out_v <= 1'b0;
            if (last_idx) begin
              state <= IDLE;
            end else begin
              idx   <= idx + Ngens'(1);
              state <= SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spike_generator_bank.md
Name: spike_generator_bank

Overview:
- Consumer end of the spike-generator programming channel and producer of a tag/count output channel.
- Holds up to 2**Ngens programmable periodic generators, each storing a period, a tick countdown and an output tag.
- On every wall-clock time-unit pulse from the time manager, it scans generator indices 0..gens_used and emits one tag/count word per generator that fires.
- Sits between the PC-side decoder (programming writes) and the tag merge toward the router.

Parameters:
Ngens, 8, index width; bank depth is 2**Ngens entries
Nperiod, 16, width of period and tick countdown
Ntag, 11, output tag width
Nct, 10, output count width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
unit_pulse  in  1  one-cycle strobe marking each wall-clock time unit
gens_used  in  Ngens  highest generator index scanned
gens_en  in  2**Ngens  per-generator enable
prog_gen_idx  in  Ngens  programming target index
prog_period  in  Nperiod  period to write
prog_ticks  in  Nperiod  initial countdown to write
prog_tag  in  Ntag  tag to write
prog_v  in  1  programming word valid
prog_a  out  1  programming word accepted (one-cycle pulse)
out_tag  out  Ntag  emitted tag
out_ct  out  Nct  emitted count
out_v  out  1  output valid
out_a  in  1  output acknowledge
overrun  out  1  sticky flag: a unit_pulse was dropped

Behaviour:
- Storage: three 2**Ngens-entry arrays (period, ticks, tag) with combinational read. Asynchronous reset clears every entry to 0.
- Reset values: prog_a=0, out_v=0, out_tag=0, out_ct=0, overrun=0, pending=0, idx=0, state=IDLE.
- Reset mid-scan or mid-emit aborts the operation immediately; no partial words survive.
- FSM states: IDLE, SCAN, EMIT.
- IDLE:
  - If unit_pulse=1 or pending=1: clear pending, set idx=0, go to SCAN. unit_pulse has priority over prog_v in the same cycle; programming is held off and prog_a stays 0.
  - Otherwise, if prog_v=1: write period, ticks and tag at prog_gen_idx and assert prog_a for exactly that cycle. Then ignore prog_v for one cycle, so a held prog_v is accepted again only after the producer has seen prog_a.
- SCAN: one cycle per index.
  - If gens_en[idx]=0 or period[idx]=0: no change to the entry.
  - Else if ticks[idx]<=1: set ticks[idx]=period[idx], load out_tag=tag[idx], out_ct=1, assert out_v, go to EMIT.
  - Else: ticks[idx]=ticks[idx]-1.
  - After a non-firing index: if idx==gens_used go to IDLE, else idx+1.
- EMIT:
  - out_v, out_tag and out_ct are held stable until a cycle with out_v=1 and out_a=1.
  - On that transfer, out_v drops the next cycle. If idx==gens_used go to IDLE, else idx+1 and SCAN.
- Firing interval: an enabled generator with period p>=1 fires every p time units. The first firing occurs on the scan where the programmed ticks value reaches <=1, so ticks=0 or 1 fires on the first scan.
- unit_pulse while not IDLE:
  - If pending=0, set pending=1.
  - If pending=1 already, drop the pulse and set overrun=1, which stays set until reset.
  - A unit_pulse in the same cycle the FSM returns to IDLE counts as pending.
- gens_used and gens_en are sampled per index during SCAN; changes mid-scan take effect at the next index.
- Scan latency with no firings: gens_used+1 cycles from start of SCAN to IDLE.
- Programming entry k while a scan is active is impossible, because writes are accepted only in IDLE.
- Nperiod arithmetic is unsigned. The decrement never underflows, because <=1 fires instead.

Test Plan:
- Reset with prog_v=1 and unit_pulse=1 held -> prog_a=0, out_v=0, overrun=0 throughout reset; after release, the first unit_pulse starts a scan before any write is accepted.
- Program gen 3: period=4, ticks=4, tag=0x155; gens_used=3, gens_en[3]=1; 12 unit_pulses with out_a=1 -> exactly 3 words, each out_tag=0x155, out_ct=1, on units 4, 8, 12.
- Gens 0 and 1 both period=1, tags 0x0A/0x0B; out_a held 0 for 5 cycles after out_v -> out_v, out_tag=0x0A stable for all 5 cycles; after ack, 0x0B follows; order always idx 0 then 1.
- gens_en[2]=0 with period=2 programmed -> no output over 10 units; then set gens_en[2]=1 -> output resumes with period 2 using the ticks value frozen while disabled.
- Stall output (out_a=0) and issue 3 unit_pulses during one scan -> pending set by the first, overrun=1 after the second; exactly one extra scan follows after the stall releases.
- unit_pulse and prog_v in the same IDLE cycle, gens_used=0xFF -> prog_a first asserts only after 256 scan cycles return the FSM to IDLE; the written values are visible on the next scan.
